// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline: operand forwarding,
// load-use stalls, branch flushes and multi-cycle execute sequencing.
module hazard_controller #(
    parameter int MC_LATENCY = 4,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MultiCycleE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              BubbleM,
    output logic              McBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // The IDLE cycle and the DONE cycle account for two of the op's cycles in E.
    localparam int          CNT_INIT_I = (MC_LATENCY > 2) ? (MC_LATENCY - 3) : 0;
    localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    mc_state_t   state;
    mc_state_t   next_state;
    logic [3:0]  cnt;
    logic [3:0]  next_cnt;
    logic        mc_stall;
    logic        lw_stall;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != ZERO_REG) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != ZERO_REG) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != ZERO_REG) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != ZERO_REG) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != ZERO_REG) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // A taken branch in E squashes the multi-cycle op, so it never starts a sequence.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        mc_stall   = 1'b0;
        case (state)
            IDLE: begin
                if (MultiCycleE && !PCSrcE) begin
                    mc_stall = 1'b1;
                    if (MC_LATENCY == 2) begin
                        next_state = DONE;
                    end else begin
                        next_state = BUSY;
                        next_cnt   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                mc_stall = 1'b1;
                if (cnt == 4'd0) begin
                    next_state = DONE;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    // Reset gates the control outputs directly so they drop without waiting for an edge.
    assign StallF  = !rst && (lw_stall || mc_stall);
    assign StallD  = !rst && (lw_stall || mc_stall);
    assign StallE  = !rst && mc_stall;
    assign BubbleM = !rst && mc_stall;
    assign FlushD  = !rst && PCSrcE;
    assign FlushE  = !rst && (lw_stall || PCSrcE) && !mc_stall;
    assign McBusy  = (state != IDLE);

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; runs MC_LATENCY=4 and MC_LATENCY=2 instances
// side by side on the same stimulus.
module tb_hazard_controller;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MultiCycleE;

    logic [1:0] fa4, fb4, fa2, fb2;
    logic       stall_f4, stall_d4, stall_e4, flush_d4, flush_e4, bubble_m4, busy4;
    logic       stall_f2, stall_d2, stall_e2, flush_d2, flush_e2, bubble_m2, busy2;

    int checks = 0;
    int errors = 0;

    hazard_controller #(.MC_LATENCY(4), .REG_AW(5)) u_lat4 (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
        .ForwardAE(fa4), .ForwardBE(fb4),
        .StallF(stall_f4), .StallD(stall_d4), .StallE(stall_e4),
        .FlushD(flush_d4), .FlushE(flush_e4), .BubbleM(bubble_m4), .McBusy(busy4)
    );

    hazard_controller #(.MC_LATENCY(2), .REG_AW(5)) u_lat2 (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
        .ForwardAE(fa2), .ForwardBE(fb2),
        .StallF(stall_f2), .StallD(stall_d2), .StallE(stall_e2),
        .FlushD(flush_d2), .FlushE(flush_e2), .BubbleM(bubble_m2), .McBusy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic check_sel(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%02b expected=%02b", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; MultiCycleE = 1'b0;
    endtask

    // Checks the four stall/flush/bubble controls of the latency-4 instance.
    task automatic check_output(input string tag, input logic sf, input logic se,
                                input logic fe, input logic bm, input logic busy);
        check_bit({tag, "_stallf"}, stall_f4, sf);
        check_bit({tag, "_stalld"}, stall_d4, sf);
        check_bit({tag, "_stalle"}, stall_e4, se);
        check_bit({tag, "_flushe"}, flush_e4, fe);
        check_bit({tag, "_bubblem"}, bubble_m4, bm);
        check_bit({tag, "_busy"}, busy4, busy);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        apply_stimulus();
        rst = 1'b1;
        #2;
        // Hazard-provoking inputs while reset is held: controls stay low, forwarding live.
        MultiCycleE = 1'b1; PCSrcE = 1'b1;
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        #1;
        check_output("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("rst_flushd", flush_d4, 1'b0);
        check_sel("rst_fwda", fa4, 2'b10);
        PCSrcE = 1'b0;
        tick();
        check_bit("rst_busy_after_edge", busy4, 1'b0);
        check_bit("rst_stalle_after_edge", stall_e4, 1'b0);
        apply_stimulus();
        rst = 1'b0;
        #1;
        check_output("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Forwarding priority
        RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
        Rs1E = 5'd5; Rs2E = 5'd6;
        #1;
        check_sel("fwd_m_prio_a", fa4, 2'b10);
        check_sel("fwd_m_prio_b", fb4, 2'b00);
        RegWriteM = 1'b0;
        #1;
        check_sel("fwd_w_a", fa4, 2'b01);
        Rs2E = 5'd5;
        #1;
        check_sel("fwd_w_b", fb4, 2'b01);
        RegWriteM = 1'b1;
        #1;
        check_sel("fwd_m_b", fb4, 2'b10);
        RegWriteW = 1'b0; RdM = 5'd9;
        #1;
        check_sel("fwd_none_a", fa4, 2'b00);
        RegWriteW = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
        #1;
        check_sel("fwd_x0_a", fa4, 2'b00);
        check_sel("fwd_x0_a_lat2", fa2, 2'b00);
        apply_stimulus();

        // Load-use
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        check_output("lw_rs2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_bit("lw_flushd", flush_d4, 1'b0);
        Rs2D = 5'd3; Rs1D = 5'd7;
        #1;
        check_output("lw_rs1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ResultSrcE = 2'b00;
        #1;
        check_output("nolw_alu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        check_output("lw_x0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        // Branch beats a multi-cycle start
        tick();
        PCSrcE = 1'b1; MultiCycleE = 1'b1;
        #1;
        check_bit("br_flushd", flush_d4, 1'b1);
        check_output("br", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_bit("br_busy_next4", busy4, 1'b0);
        check_bit("br_busy_next2", busy2, 1'b0);
        apply_stimulus();

        // Multi-cycle op, MultiCycleE held: cycle 1 (IDLE)
        tick();
        MultiCycleE = 1'b1;
        #1;
        check_output("mc_c1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_bit("mc2_c1_stalle", stall_e2, 1'b1);
        check_bit("mc2_c1_busy", busy2, 1'b0);
        tick();
        #1;
        check_output("mc_c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_bit("mc2_c2_stalle", stall_e2, 1'b0);
        check_bit("mc2_c2_bubblem", bubble_m2, 1'b0);
        check_bit("mc2_c2_busy", busy2, 1'b1);
        tick();
        // Load-use alongside the hold: E held, not flushed.
        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
        #1;
        check_output("mc_c3_lw", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_bit("mc2_c3_flushe", flush_e2, 1'b0);
        check_bit("mc2_c3_busy", busy2, 1'b0);
        ResultSrcE = 2'b00; RdE = 5'd0; Rs1D = 5'd0;
        tick();
        #1;
        check_output("mc_c4_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_bit("mc2_c4_stalle", stall_e2, 1'b0);
        check_bit("mc2_c4_busy", busy2, 1'b1);
        MultiCycleE = 1'b0;
        tick();
        #1;
        check_output("mc_c5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("mc2_c5_busy", busy2, 1'b0);

        // Asynchronous reset in BUSY, then a fresh sequence
        MultiCycleE = 1'b1;
        tick();
        check_output("rmid_c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_bit("rmid_stalle", stall_e4, 1'b0);
        check_bit("rmid_bubblem", bubble_m4, 1'b0);
        check_bit("rmid_busy", busy4, 1'b0);
        rst = 1'b0;
        #1;
        check_output("rerun_c1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("rerun_c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("rerun_c3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("rerun_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        MultiCycleE = 1'b0;
        tick();
        check_output("rerun_c5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives the execute stage's ForwardAE/ForwardBE selects.
- Detects load-use hazards and flushes on taken branches/jumps.
- Sequences multi-cycle execute operations (MUL/DIV class) by holding F/D/E and injecting bubbles into M until the operation completes.

Parameters:
- MC_LATENCY, 4, total cycles a multi-cycle op occupies E; legal range 2..16.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- Rs1D, Rs2D  in  REG_AW  source registers of the instruction in D
- Rs1E, Rs2E  in  REG_AW  source registers of the instruction in E
- RdE, RdM, RdW  in  REG_AW  destination registers in E/M/W
- RegWriteM, RegWriteW  in  1  write-enable of the instruction in M/W
- ResultSrcE  in  2  result select of E; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in E
- MultiCycleE  in  1  instruction in E is a multi-cycle op
- ForwardAE, ForwardBE  out  2  00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE  out  1  clear the IF/ID and ID/EX registers
- BubbleM  out  1  clear the EX/MEM register
- McBusy  out  1  multi-cycle sequencer not in IDLE

Behaviour:
- Forwarding is combinational. ForwardAE:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - M has priority over W. ForwardBE is identical, using Rs2E.
- lwStall = (ResultSrcE==2'b01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Sequencer FSM has states IDLE, BUSY, DONE, plus a 4-bit down-counter cnt. Both are registered; rst forces IDLE and cnt=0 immediately, including mid-operation.
- IDLE:
  - If MultiCycleE & !PCSrcE, then mcStall=1 for this cycle.
  - Next state is DONE if MC_LATENCY==2; otherwise BUSY with cnt=MC_LATENCY-3.
  - Else remain in IDLE.
- BUSY: mcStall=1. If cnt==0, next state is DONE; else cnt decrements.
- DONE: mcStall=0, so the op advances to M at the next edge. Next state is IDLE unconditionally; no restart from DONE.
- Resulting occupancy:
  - The op occupies E for exactly MC_LATENCY cycles.
  - Stalls are asserted for its first MC_LATENCY-1 cycles.
- Output equations (combinational from state and inputs):
  - StallF = StallD = lwStall | mcStall
  - StallE = mcStall
  - BubbleM = mcStall
  - FlushD = PCSrcE
  - FlushE = (lwStall | PCSrcE) & !mcStall
  - McBusy = (state != IDLE)
- Simultaneous events:
  - If PCSrcE and MultiCycleE are both high, PCSrcE wins and no sequence starts.
  - lwStall during mcStall is subsumed by mcStall; E is held, not flushed.
- While rst is high: all stall/flush/bubble outputs are 0, McBusy is 0, and forwarding follows its equations.

Test Plan:
- Forward priority: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=6 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01. Then RdM=RdW=0 with Rs1E=0 -> ForwardAE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0. Then RdE=0 -> all stall/flush outputs 0.
- Branch: PCSrcE=1 with MultiCycleE=1 -> FlushD=FlushE=1, McBusy stays 0 on the next cycle, no stall.
- Multi-cycle op, MC_LATENCY=4, MultiCycleE held high:
  - StallE=BubbleM=1 for exactly 3 cycles, then 0 for 1 cycle (DONE).
  - McBusy=1 for cycles 2-4.
  - State returns to IDLE on cycle 5.
  - Repeat with MC_LATENCY=2 -> exactly 1 stall cycle.
- Reset mid-op: assert rst asynchronously during BUSY -> StallE, BubbleM and McBusy drop without waiting for a clock edge. After release with MultiCycleE=1, a fresh full sequence restarts.
